vregfile: RTL
=============

VREGFILE -- requirements
Module: vregfile

Interface
REQ-001 SHALL have parameter NREGS, default 8, meaning the number of vector registers (register address width 3).
REQ-002 SHALL have parameter LANES, default 5, meaning 32-bit elements per vector register.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have ports VRA1 and VRA2, input, 3 each, meaning read register addresses for the A and B operands.
REQ-006 SHALL have ports VRD1 and VRD2, output, [31:0] x [0:4] each, meaning read data feeding the vector ALU VSrcA and VSrcB.
REQ-007 SHALL have port VWE3, input, 1, meaning vector write enable for the ALU result.
REQ-008 SHALL have port VWA3, input, 3, meaning the vector write register address.
REQ-009 SHALL have port VWD3, input, [31:0] x [0:4], meaning vector write data (VALUResult).
REQ-010 SHALL have port index, input, 3, meaning the active lane count shared with the ALU.
REQ-011 SHALL have port ld_start, input, 1, meaning a request to start a serial element load.
REQ-012 SHALL have port ld_reg, input, 3, meaning the destination register for the load, sampled at start.
REQ-013 SHALL have ports ld_valid (input, 1), ld_data (input, 32) and ld_ready (output, 1), meaning the per-element load handshake.
REQ-014 SHALL have ports busy (output, 1), meaning a load is in progress, and ld_done (output, 1), meaning a one-cycle load-completion pulse.

Function
REQ-015 SHALL drive VRD1[i] and VRD2[i] combinationally from stored lane i of VRA1 and VRA2, with no write bypass; a same-cycle write becomes visible after the edge.
REQ-016 SHALL compute the effective lane count n = min(index, LANES); index values 6 and 7 SHALL act as 5.
REQ-017 SHALL, on an edge with VWE3=1, write VWD3[i] into lane i of register VWA3 for i < n only; lanes i >= n SHALL retain their value, and n = 0 SHALL write nothing.
REQ-018 SHALL implement the FSM states IDLE, LOAD and DONE.
REQ-019 SHALL, in IDLE with ld_start=1, latch ld_reg as the destination, latch n as the beat count, clear the lane pointer to 0, and move to LOAD, or to DONE if the count is 0.
REQ-020 SHALL ignore ld_start outside IDLE.
REQ-021 SHALL assert ld_ready only in LOAD and only when not (VWE3=1 and VWA3 equal to the latched destination).
REQ-022 SHALL treat a beat as ld_valid && ld_ready at an edge: write ld_data to the pointed lane of the destination, then increment the pointer.
REQ-023 SHALL move to DONE on the beat that writes lane count-1.
REQ-024 SHALL, in DONE, assert ld_done for exactly one cycle and return to IDLE on the next edge.
REQ-025 SHALL assert busy exactly when the state is LOAD or DONE.
REQ-026 SHALL allow ALU writes to other registers, or to the destination while ld_ready is 0, at any time, so a write and a beat never target the same register in the same cycle.
REQ-027 SHALL leave lanes of the destination not yet loaded unchanged.

Reset
REQ-028 SHALL, while reset=0 and independent of clk, clear all NREGS x LANES words to 0, set the state to IDLE, and drive busy, ld_ready and ld_done to 0.
REQ-029 SHALL abort a load in progress on reset assertion, with no partial-load completion pulse after reset release.

Verification
REQ-030 SHALL cover this scenario: reset, then read all registers -> every VRD lane is 0, and busy, ld_ready and ld_done are 0.
REQ-031 SHALL cover this scenario: VWE3=1, VWA3=2, index=3, VWD3={1,2,3,4,5} over a register 2 holding all 0xFFFFFFFF -> register 2 reads {1,2,3,0xFFFFFFFF,0xFFFFFFFF}; with index=7 and the same write -> {1,2,3,4,5}.
REQ-032 SHALL cover this scenario: ld_start, ld_reg=4, index=5, ld_valid held 1 with data 10..14 -> register 4 reads {10..14}, busy is high for 6 cycles, and ld_done pulses once.
REQ-033 SHALL cover this scenario: during a load to register 4, VWE3=1 with VWA3=4 for 2 cycles -> ld_ready is 0 for those cycles, no beat is consumed, and the final contents are the loaded data.
REQ-034 SHALL cover this scenario: ld_start with index=0 -> the DONE cycle follows immediately, ld_done pulses, and no register changes; a second ld_start while busy is ignored.
REQ-035 SHALL cover this scenario: reset asserted after 2 beats of a 5-beat load -> all registers read 0, the state is IDLE, and no ld_done pulse occurs.

Source files
------------

// File: rtl/vregfile.sv
// Vector register file: NREGS x LANES 32-bit words, two combinational read ports,
// one lane-masked ALU write port and a serial element-load engine.
module vregfile #(
  parameter int NREGS = 8,
  parameter int LANES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  VRA1,
  input  logic [2:0]  VRA2,
  output logic [31:0] VRD1 [0:LANES-1],
  output logic [31:0] VRD2 [0:LANES-1],
  input  logic        VWE3,
  input  logic [2:0]  VWA3,
  input  logic [31:0] VWD3 [0:LANES-1],
  input  logic [2:0]  index,
  input  logic        ld_start,
  input  logic [2:0]  ld_reg,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        busy,
  output logic        ld_done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t      r_state;
  logic [2:0]  r_dst;
  logic [2:0]  r_cnt;
  logic [2:0]  r_ptr;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_mem [0:NREGS-1][0:LANES-1];

  logic [2:0]  w_n;
  logic        w_beat;

  // Effective lane count saturates at LANES (index 6/7 behave as 5).
  always_comb begin
    w_n = index;
    if (32'(index) > 32'(LANES)) w_n = 3'(LANES);
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      VRD1[l] = r_mem[VRA1][l];
      VRD2[l] = r_mem[VRA2][l];
    end
  end

  // A conflicting ALU write stalls the load, so a beat and an ALU write never share a register.
  always_comb begin
    ld_ready = (r_state == LOAD) && !(VWE3 && (VWA3 == r_dst));
    w_beat   = ld_valid && ld_ready;
  end

  assign busy    = r_busy;
  assign ld_done = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREGS; r++)
        for (int unsigned l = 0; l < LANES; l++)
          r_mem[r][l] <= '0;
    end else begin
      if (VWE3) begin
        for (int unsigned l = 0; l < LANES; l++)
          if (l < 32'(w_n)) r_mem[VWA3][l] <= VWD3[l];
      end
      if (w_beat) r_mem[r_dst][r_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ld_start) begin
            r_dst  <= ld_reg;
            r_cnt  <= w_n;
            r_ptr  <= '0;
            r_busy <= 1'b1;
            if (w_n == 3'd0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_beat) begin
            r_ptr <= r_ptr + 3'd1;
            if (r_ptr == r_cnt - 3'd1) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
